// File: rtl/opq_op_dispatch_pkg.sv
// opq_dispatch_pkg: op and state encodings plus the occupancy-width helper
// shared by the op dispatcher, its interface and its occupancy counter.

`ifndef TOP_DEPTH
`define TOP_DEPTH 8
`endif

`ifndef TOP_CHANWIDTH
`define TOP_CHANWIDTH 32
`endif

package opq_dispatch_pkg;

  // Command opcodes as seen on cmd_op / resp_op
  typedef enum logic [1:0] {
    OP_ENQ_BACK  = 2'd0,
    OP_ENQ_FRONT = 2'd1,
    OP_DEQ_FRONT = 2'd2,
    OP_DEQ_BACK  = 2'd3
  } op_e;

  // Dispatcher control states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_e;

  // Bits needed to hold a count from 0 up to and including depth
  function automatic int occWidth(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Enqueues grow the queue, dequeues shrink it
  function automatic logic isEnqueue(input op_e op);
    return (op == OP_ENQ_BACK) || (op == OP_ENQ_FRONT);
  endfunction

endpackage

// File: rtl/opq_op_dispatch_if.sv
// opq_op_dispatch_if: command/response streams plus the four req/cpl
// operation ports toward the double-ended queue. The master modport is the
// dispatcher; the slave modport is its environment (host and queue).

interface opq_op_dispatch_if #(
  parameter int p_bitwidth = `TOP_CHANWIDTH
);

  logic                  cmd_val;
  logic                  cmd_rdy;
  logic [1:0]            cmd_op;
  logic [p_bitwidth-1:0] cmd_data;

  logic                  resp_val;
  logic                  resp_rdy;
  logic [1:0]            resp_op;
  logic [p_bitwidth-1:0] resp_data;
  logic                  resp_err;

  logic                  enq_back_req;
  logic                  enq_front_req;
  logic                  deq_front_req;
  logic                  deq_back_req;

  logic                  enq_back_cpl;
  logic                  enq_front_cpl;
  logic                  deq_front_cpl;
  logic                  deq_back_cpl;

  logic [p_bitwidth-1:0] enq_back_data;
  logic [p_bitwidth-1:0] enq_front_data;
  logic [p_bitwidth-1:0] deq_front_data;
  logic [p_bitwidth-1:0] deq_back_data;

  modport master (
    input  cmd_val, cmd_op, cmd_data, resp_rdy,
    input  enq_back_cpl, enq_front_cpl, deq_front_cpl, deq_back_cpl,
    input  deq_front_data, deq_back_data,
    output cmd_rdy, resp_val, resp_op, resp_data, resp_err,
    output enq_back_req, enq_front_req, deq_front_req, deq_back_req,
    output enq_back_data, enq_front_data
  );

  modport slave (
    output cmd_val, cmd_op, cmd_data, resp_rdy,
    output enq_back_cpl, enq_front_cpl, deq_front_cpl, deq_back_cpl,
    output deq_front_data, deq_back_data,
    input  cmd_rdy, resp_val, resp_op, resp_data, resp_err,
    input  enq_back_req, enq_front_req, deq_front_req, deq_back_req,
    input  enq_back_data, enq_front_data
  );

endinterface

// File: rtl/opq_op_dispatch_occ_counter.sv
// opq_occ_counter: saturating up/down entry counter for the downstream
// queue, with full (count == p_depth) and empty (count == 0) flags.

module opq_occ_counter
  import opq_dispatch_pkg::*;
#(
  parameter int p_depth = `TOP_DEPTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_inc,
  input  logic                         i_dec,
  output logic [occWidth(p_depth)-1:0] o_count,
  output logic                         o_full,
  output logic                         o_empty
);

  localparam int              lp_w   = occWidth(p_depth);
  localparam logic [lp_w-1:0] lp_max = lp_w'(p_depth);
  localparam logic [lp_w-1:0] lp_one = lp_w'(1);

  logic [lp_w-1:0] r_count;

  // Count up on enqueue and down on dequeue, holding at either bound
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
    end else if (i_inc && !i_dec && (r_count != lp_max)) begin
      r_count <= r_count + lp_one;
    end else if (i_dec && !i_inc && (r_count != '0)) begin
      r_count <= r_count - lp_one;
    end
  end

  assign o_count = r_count;
  assign o_full  = (r_count == lp_max);
  assign o_empty = (r_count == '0);

endmodule

// File: rtl/opq_op_dispatch.sv
// opq_op_dispatch: turns a valid/ready command stream into one-at-a-time
// req/cpl operations on the double-ended queue and returns each result on a
// valid/ready response stream. Occupancy is always tracked.
// Build option: OPQ_DISPATCH_BOUNDS_CHECK_EN rejects enqueue-when-full and
// dequeue-when-empty with resp_err=1 instead of forwarding them.

module opq_op_dispatch
  import opq_dispatch_pkg::*;
#(
  parameter int p_depth    = `TOP_DEPTH,
  parameter int p_bitwidth = `TOP_CHANWIDTH
) (
  input  logic                         clk,
  input  logic                         rst,
  opq_op_dispatch_if.master            bus,
  output logic [occWidth(p_depth)-1:0] occupancy
);

  state_e                r_state;
  state_e                w_nextState;

  op_e                   r_op;
  logic [p_bitwidth-1:0] r_data;
  logic [3:0]            r_req;

  logic                  r_respVal;
  logic [1:0]            r_respOp;
  logic [p_bitwidth-1:0] r_respData;
  logic                  r_respErr;

  op_e                   w_cmdOp;
  logic                  w_accept;
  logic                  w_illegal;
  logic                  w_cplHit;
  logic                  w_respDone;
  logic [3:0]            w_cplVec;
  logic [p_bitwidth-1:0] w_deqData;
  logic                  w_occInc;
  logic                  w_occDec;
  logic                  w_full;
  logic                  w_empty;

  // Completion lines in the same bit order as r_req (bit index == opcode)
  assign w_cplVec = {bus.deq_back_cpl, bus.deq_front_cpl,
                     bus.enq_front_cpl, bus.enq_back_cpl};

  // Next-state decode: accept in IDLE, wait for the matching cpl in ISSUE,
  // wait for the response handshake in RESP
  always_comb begin
    w_nextState = r_state;
    w_cmdOp     = op_e'(bus.cmd_op);
    w_accept    = 1'b0;
    w_illegal   = 1'b0;
    w_cplHit    = 1'b0;
    w_respDone  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.cmd_val) begin
          w_accept = 1'b1;
`ifdef OPQ_DISPATCH_BOUNDS_CHECK_EN
          w_illegal = isEnqueue(w_cmdOp) ? w_full : w_empty;
`endif
          w_nextState = w_illegal ? ST_RESP : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        w_cplHit = |(w_cplVec & r_req);
        if (w_cplHit) begin
          w_nextState = ST_RESP;
        end
      end
      ST_RESP: begin
        if (bus.resp_rdy) begin
          w_respDone  = 1'b1;
          w_nextState = ST_IDLE;
        end
      end
      default: w_nextState = ST_IDLE;
    endcase
  end

  // Control state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Select the dequeue result that belongs to the latched op
  always_comb begin
    w_deqData = '0;
    case (r_op)
      OP_DEQ_FRONT: w_deqData = bus.deq_front_data;
      OP_DEQ_BACK:  w_deqData = bus.deq_back_data;
      default:      w_deqData = '0;
    endcase
  end

  // Latch the command, drive the one-hot request, and load the response
  // registers on completion or on an immediate rejection
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_op       <= OP_ENQ_BACK;
      r_data     <= '0;
      r_req      <= '0;
      r_respVal  <= 1'b0;
      r_respOp   <= '0;
      r_respData <= '0;
      r_respErr  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_op   <= w_cmdOp;
        r_data <= bus.cmd_data;
      end

      if (w_accept && !w_illegal) begin
        r_req <= 4'b0001 << w_cmdOp;
      end else if (w_cplHit) begin
        r_req <= '0;
      end

      if (w_accept && w_illegal) begin
        r_respVal  <= 1'b1;
        r_respOp   <= w_cmdOp;
        r_respData <= '0;
        r_respErr  <= 1'b1;
      end else if (w_cplHit) begin
        r_respVal  <= 1'b1;
        r_respOp   <= r_op;
        r_respData <= w_deqData;
        r_respErr  <= 1'b0;
      end else if (w_respDone) begin
        r_respVal  <= 1'b0;
      end
    end
  end

  assign w_occInc = w_cplHit &&  isEnqueue(r_op);
  assign w_occDec = w_cplHit && !isEnqueue(r_op);

  opq_occ_counter #(
    .p_depth (p_depth)
  ) u_occCounter (
    .clk     (clk),
    .rst     (rst),
    .i_inc   (w_occInc),
    .i_dec   (w_occDec),
    .o_count (occupancy),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

`ifndef OPQ_DISPATCH_BOUNDS_CHECK_EN
  // Flags only feed the legality check, which this build leaves out
  logic w_unusedFlags;
  assign w_unusedFlags = w_full | w_empty;
`endif

  assign bus.cmd_rdy        = (r_state == ST_IDLE);
  assign bus.enq_back_req   = r_req[0];
  assign bus.enq_front_req  = r_req[1];
  assign bus.deq_front_req  = r_req[2];
  assign bus.deq_back_req   = r_req[3];
  assign bus.enq_back_data  = r_data;
  assign bus.enq_front_data = r_data;
  assign bus.resp_val       = r_respVal;
  assign bus.resp_op        = r_respOp;
  assign bus.resp_data      = r_respData;
  assign bus.resp_err       = r_respErr;

endmodule

// File: tb/tb_opq_op_dispatch.sv
// tb_opq_op_dispatch: directed stimulus for opq_op_dispatch (depth 4, 8-bit
// data) against a behavioural deque with a 1-3 cycle completion delay.
// Expected responses are queued as commands are issued; a monitor pops and
// compares each response handshake.

module tb_opq_op_dispatch;
  import opq_dispatch_pkg::*;

  typedef struct {
    logic [1:0] op;
    logic [7:0] data;
    logic       err;
  } exp_t;

  logic       clk;
  logic       rst;
  logic [2:0] occupancy;

  int checks = 0;
  int errors = 0;

  exp_t       expQ[$];
  logic [7:0] model[$];

  int         holdCycles;
  logic [3:0] mCpl;
  logic [7:0] mDeqFront;
  logic [7:0] mDeqBack;
  logic       spurCpl;
  logic [3:0] reqVec;
  int         reqPulses = 0;

  opq_op_dispatch_if #(.p_bitwidth(8)) ifc ();

  opq_op_dispatch #(
    .p_depth    (4),
    .p_bitwidth (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (ifc),
    .occupancy (occupancy)
  );

  assign reqVec             = {ifc.deq_back_req, ifc.deq_front_req,
                               ifc.enq_front_req, ifc.enq_back_req};
  assign ifc.enq_back_cpl   = mCpl[0];
  assign ifc.enq_front_cpl  = mCpl[1];
  assign ifc.deq_front_cpl  = mCpl[2];
  assign ifc.deq_back_cpl   = mCpl[3] | spurCpl;
  assign ifc.deq_front_data = mDeqFront;
  assign ifc.deq_back_data  = spurCpl ? 8'hEE : mDeqBack;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running, required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] op, input logic [7:0] data,
                               input logic [7:0] expData, input logic expErr,
                               input bit expectResp);
    int guard = 0;
    while (!ifc.cmd_rdy && guard < 100) begin
      tick();
      guard++;
    end
    if (guard >= 100) begin
      checks++;
      errors++;
      $display("[TB] FAIL cmd_rdy_timeout: got cmd_rdy=0 for 100 cycles, required 1");
    end
    ifc.cmd_val  = 1'b1;
    ifc.cmd_op   = op;
    ifc.cmd_data = data;
    if (expectResp) expQ.push_back('{op: op, data: expData, err: expErr});
    tick();
    ifc.cmd_val  = 1'b0;
    ifc.cmd_op   = 2'd0;
    ifc.cmd_data = 8'h00;
  endtask

  task automatic waitDrain();
    int guard = 0;
    while ((expQ.size() != 0 || !ifc.cmd_rdy) && guard < 100) begin
      tick();
      guard++;
    end
    if (guard >= 100) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain_timeout: got %0d pending responses, required 0", expQ.size());
    end
  endtask

  task automatic doReset();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
  endtask

  // Behavioural deque: answers the single active request after holdCycles
  // (or a random 1-3) cycles with a one-cycle cpl pulse
  initial begin : queueModel
    int cnt;
    bit busy;
    busy = 1'b0;
    cnt = 0;
    mCpl = 4'b0;
    mDeqFront = 8'h00;
    mDeqBack = 8'h00;
    forever begin
      tick();
      mCpl = 4'b0;
      if (!rst) begin
        busy = 1'b0;
        model.delete();
      end else begin
        if (!busy && reqVec != 4'b0) begin
          busy = 1'b1;
          cnt = (holdCycles != 0) ? holdCycles : int'($urandom_range(3, 1));
        end
        if (busy) begin
          cnt--;
          if (cnt <= 0) begin
            busy = 1'b0;
            if (reqVec[0]) begin
              model.push_back(ifc.enq_back_data);
              mCpl[0] = 1'b1;
            end else if (reqVec[1]) begin
              model.push_front(ifc.enq_front_data);
              mCpl[1] = 1'b1;
            end else if (reqVec[2]) begin
              if (model.size() != 0) mDeqFront = model.pop_front();
              else mDeqFront = 8'h00;
              mCpl[2] = 1'b1;
            end else if (reqVec[3]) begin
              if (model.size() != 0) mDeqBack = model.pop_back();
              else mDeqBack = 8'h00;
              mCpl[3] = 1'b1;
            end
          end
        end
      end
    end
  end

  // Response monitor: every handshake must match the oldest expectation
  initial begin : respMonitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst && ifc.resp_val && ifc.resp_rdy) begin
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_resp: got op=%0d data=0x%0h err=%0b, required no response",
                   ifc.resp_op, ifc.resp_data, ifc.resp_err);
        end else begin
          e = expQ.pop_front();
          checkOutput("resp {op,data,err}", {ifc.resp_op, ifc.resp_data, ifc.resp_err},
                      {e.op, e.data, e.err});
        end
      end
    end
  end

  // Count request pulses so rejected commands can be shown to issue none
  initial begin : reqMonitor
    logic prevAny;
    prevAny = 1'b0;
    forever begin
      @(negedge clk);
      if (|reqVec && !prevAny) reqPulses++;
      prevAny = |reqVec;
    end
  end

  initial begin : mainSeq
    int pulses;
    ifc.cmd_val  = 1'b0;
    ifc.cmd_op   = 2'd0;
    ifc.cmd_data = 8'h00;
    ifc.resp_rdy = 1'b1;
    holdCycles   = 0;
    spurCpl      = 1'b0;
    rst          = 1'b1;
    #2 rst = 1'b0;
    repeat (3) tick();

    checkOutput("reset reqs", {28'd0, reqVec}, 32'd0);
    checkOutput("reset resp_val", {31'd0, ifc.resp_val}, 32'd0);
    checkOutput("reset resp_op/err", {29'd0, ifc.resp_op, ifc.resp_err}, 32'd0);
    checkOutput("reset resp_data", {24'd0, ifc.resp_data}, 32'd0);
    checkOutput("reset enq data", {16'd0, ifc.enq_back_data, ifc.enq_front_data}, 32'd0);
    checkOutput("reset occupancy", {29'd0, occupancy}, 32'd0);
    rst = 1'b1;
    tick();
    checkOutput("idle cmd_rdy", {31'd0, ifc.cmd_rdy}, 32'd1);

    // Basic enqueue/dequeue at both ends, first with the fastest completion
    holdCycles = 1;
    applyStimulus(OP_ENQ_BACK, 8'h11, 8'h00, 1'b0, 1'b1);
    checkOutput("enq_back_req at N+1", {31'd0, ifc.enq_back_req}, 32'd1);
    checkOutput("enq data latched", {16'd0, ifc.enq_back_data, ifc.enq_front_data}, 32'h1111);
    checkOutput("no resp at N+1", {31'd0, ifc.resp_val}, 32'd0);
    tick();
    checkOutput("resp at N+2", {31'd0, ifc.resp_val}, 32'd1);
    checkOutput("req dropped at N+2", {28'd0, reqVec}, 32'd0);
    holdCycles = 0;
    applyStimulus(OP_ENQ_FRONT, 8'h22, 8'h00, 1'b0, 1'b1);
    waitDrain();
    checkOutput("occupancy after 2 enq", {29'd0, occupancy}, 32'd2);
    applyStimulus(OP_DEQ_BACK, 8'h00, 8'h11, 1'b0, 1'b1);
    applyStimulus(OP_DEQ_FRONT, 8'h00, 8'h22, 1'b0, 1'b1);
    waitDrain();
    checkOutput("occupancy after 2 deq", {29'd0, occupancy}, 32'd0);

    // Fill, then push one more
    applyStimulus(OP_ENQ_BACK, 8'hA1, 8'h00, 1'b0, 1'b1);
    applyStimulus(OP_ENQ_BACK, 8'hA2, 8'h00, 1'b0, 1'b1);
    applyStimulus(OP_ENQ_BACK, 8'hA3, 8'h00, 1'b0, 1'b1);
    applyStimulus(OP_ENQ_BACK, 8'hA4, 8'h00, 1'b0, 1'b1);
    waitDrain();
    checkOutput("occupancy full", {29'd0, occupancy}, 32'd4);
    pulses = reqPulses;
`ifdef OPQ_DISPATCH_BOUNDS_CHECK_EN
    applyStimulus(OP_ENQ_BACK, 8'h55, 8'h00, 1'b1, 1'b1);
    checkOutput("full reject resp at N+1", {31'd0, ifc.resp_val}, 32'd1);
    checkOutput("full reject no req", {31'd0, ifc.enq_back_req}, 32'd0);
    waitDrain();
    checkOutput("full reject req pulses", reqPulses, pulses);
`else
    applyStimulus(OP_ENQ_BACK, 8'h55, 8'h00, 1'b0, 1'b1);
    checkOutput("full forwarded enq_back_req", {31'd0, ifc.enq_back_req}, 32'd1);
    waitDrain();
    checkOutput("full forwarded req pulses", reqPulses, pulses + 1);
`endif
    checkOutput("occupancy saturated", {29'd0, occupancy}, 32'd4);
    doReset();

`ifdef OPQ_DISPATCH_BOUNDS_CHECK_EN
    // Dequeue from an empty queue is rejected one cycle after accept
    pulses = reqPulses;
    applyStimulus(OP_DEQ_FRONT, 8'h00, 8'h00, 1'b1, 1'b1);
    checkOutput("empty reject resp at N+1", {31'd0, ifc.resp_val}, 32'd1);
    checkOutput("empty reject err/data", {23'd0, ifc.resp_err, ifc.resp_data}, 32'h100);
    waitDrain();
    checkOutput("empty reject req pulses", reqPulses, pulses);
`endif

    // Response back-pressure with a spurious completion during RESP
    applyStimulus(OP_ENQ_BACK, 8'h77, 8'h00, 1'b0, 1'b1);
    applyStimulus(OP_ENQ_BACK, 8'h78, 8'h00, 1'b0, 1'b1);
    waitDrain();
    ifc.resp_rdy = 1'b0;
    applyStimulus(OP_DEQ_BACK, 8'h00, 8'h78, 1'b0, 1'b1);
    begin
      int guard = 0;
      while (!ifc.resp_val && guard < 20) begin
        tick();
        guard++;
      end
      if (guard >= 20) begin
        checks++;
        errors++;
        $display("[TB] FAIL resp_timeout: got resp_val=0 for 20 cycles, required 1");
      end
    end
    for (int i = 0; i < 5; i++) begin
      checkOutput("held resp {val,data,cmd_rdy}",
                  {22'd0, ifc.resp_val, ifc.resp_data, ifc.cmd_rdy}, {22'd0, 1'b1, 8'h78, 1'b0});
      spurCpl = (i == 1);
      tick();
    end
    spurCpl = 1'b0;
    checkOutput("occupancy after spurious cpl", {29'd0, occupancy}, 32'd1);
    ifc.resp_rdy = 1'b1;
    waitDrain();

    // Reset while a request is outstanding abandons it without a response
    holdCycles = 50;
    applyStimulus(OP_ENQ_FRONT, 8'h33, 8'h00, 1'b0, 1'b0);
    checkOutput("enq_front_req before reset", {31'd0, ifc.enq_front_req}, 32'd1);
    tick();
    #2 rst = 1'b0;
    #1;
    checkOutput("req dropped by reset", {28'd0, reqVec}, 32'd0);
    checkOutput("occupancy cleared by reset", {29'd0, occupancy}, 32'd0);
    tick();
    tick();
    holdCycles = 0;
    rst = 1'b1;
    tick();
    applyStimulus(OP_ENQ_BACK, 8'h44, 8'h00, 1'b0, 1'b1);
    waitDrain();
    checkOutput("occupancy after reset enq", {29'd0, occupancy}, 32'd1);
    applyStimulus(OP_DEQ_FRONT, 8'h00, 8'h44, 1'b0, 1'b1);
    waitDrain();
    checkOutput("occupancy final", {29'd0, occupancy}, 32'd0);
    repeat (3) tick();
    checkOutput("scoreboard empty", expQ.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
